instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the 16-bit CPU. Owns the program counter, drives the program ROM's address/chip-enable, and delivers each `raw_instruction` with its address to the `DECODER` through a valid/ready handshake. A 2-entry buffer absorbs decoder stalls, and a redirect input loads a new PC and squashes all younger fetches for branches.

## Interface
- `ADDR_WIDTH`, 16, ROM address / PC width
- `INSTR_WIDTH`, 16, instruction width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rom_ce`  out  1  fetch request to the synchronous ROM this cycle
- `rom_address`  out  ADDR_WIDTH  fetch address; always equals the internal `fetch_pc`
- `rom_data`  in  INSTR_WIDTH  ROM read data, valid in the cycle after the `rom_ce` cycle
- `halt`  in  1  level; suppresses new fetches
- `redirect_valid`  in  1  one-cycle pulse: load `redirect_pc`, flush
- `redirect_pc`  in  ADDR_WIDTH  new fetch address
- `instr_valid`  out  1  buffer head is valid
- `instr_ready`  in  1  decoder accepts the head
- `raw_instruction`  out  INSTR_WIDTH  buffer head instruction
- `instr_pc`  out  ADDR_WIDTH  address of `raw_instruction`
- `pc`  out  ADDR_WIDTH  current `fetch_pc`, for debug/status

## Operation
- State:
  - `fetch_pc`
  - in-flight flag plus `inflight_pc`
  - 2-entry FIFO of {instruction, pc}, with `count` in 0..2
- `pop = instr_valid & instr_ready`.
- `rom_ce = !redirect_valid & !halt & (count + inflight - pop < 2)`. This is combinational from inputs and registered state.
- On an issue:
  - `inflight <= 1`, `inflight_pc <= fetch_pc`.
  - `fetch_pc <= fetch_pc + 1`, modulo 2^ADDR_WIDTH, so 0xFFFF wraps to 0x0000.
- On no issue: `inflight <= 0`.
- While `inflight` is set, `rom_data` is pushed into the FIFO with `inflight_pc`.
- Push and pop in the same cycle are both allowed; `count` is unchanged.
- Buffer accounting guarantees a push never finds the FIFO full. Any overflow is a design error, to be caught by an assertion.
- FIFO order is strict program order. There is no loss and no duplication.
- Redirect, in the cycle `redirect_valid` = 1:
  - No issue.
  - `fetch_pc <= redirect_pc`; `count <= 0`; `inflight <= 0`.
  - Any `rom_data` returning in this cycle is discarded.
  - A pop in the redirect cycle still completes. Discarding that instruction is the consumer's responsibility.
- Halt:
  - Blocks issue only.
  - An in-flight fetch still lands, and buffered entries still drain.
  - Redirect during halt updates the PC and flushes; fetching resumes from `redirect_pc` when halt drops.
- Redirect and halt in the same cycle: both apply.

## Timing
- Reset values:
  - `fetch_pc` = `pc` = `rom_address` = RESET_PC
  - `rom_ce` = 0 (asserted combinationally in the first cycle after release if halt = 0)
  - `instr_valid` = 0
  - `raw_instruction` = 0
  - `instr_pc` = 0
  - `count` = 0, `inflight` = 0
- Reset asserted mid-operation takes effect immediately and asynchronously: buffer and in-flight contents are lost, and outputs return to their reset values.
- Latency: issue in cycle N; data captured at the end of N+1; `instr_valid` high in N+2.
- Throughput: 1 instruction/cycle with `instr_ready` held high.
- Redirect latency: redirect in cycle R; `rom_ce` = 1 with `rom_address = redirect_pc` in R+1; first new `instr_valid` in R+3; `instr_valid` = 0 in R+1 and R+2.
- While `instr_valid` = 0, `raw_instruction`/`instr_pc` hold their last value and are don't-care.
- `instr_valid`, `raw_instruction` and `instr_pc` come from registers only; there is no combinational path from `instr_ready` to them.

## Test plan
- **Reset and stream:** ROM[i] = 0x1000+i, `instr_ready` = 1, release `rst_n` → `rom_ce` = 1, address 0 in cycle 0; `instr_valid` in cycle 2 with 0x1000/pc 0; then 0x1001, 0x1002… on consecutive cycles.
- **Backpressure:** drop `instr_ready` for 5 cycles after the first valid → `count` reaches 2, `rom_ce` = 0 while full, head holds steady. On release, instructions continue in exact sequence with none lost or duplicated.
- **Redirect with full buffer and fetch in flight:** `redirect_pc` = 0x0040 → `instr_valid` = 0 for 2 cycles; `rom_address` = 0x0040 with `rom_ce` = 1 in R+1; next delivered is ROM[0x40]/pc 0x0040 in R+3; squashed words never appear.
- **Wrap:** redirect to 0xFFFE → delivered pcs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Halt:** raise `halt` mid-stream → `rom_ce` = 0 next cycle; in-flight and buffered instructions drain; lowering `halt` resumes at the next sequential address with no gap or repeat. Redirect during halt resumes at `redirect_pc`.
- **Async reset mid-stream:** pulse `rst_n` low between clock edges → `instr_valid` and `rom_ce` drop immediately, `pc` = RESET_PC; after release, the stream restarts from ROM[RESET_PC].

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage for the 16-bit CPU.
// Owns the program counter, issues reads to a synchronous program ROM and
// hands {instruction, pc} pairs to the decoder through a 2-entry buffer.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rom_ce            fetch request to the ROM this cycle (combinational)
//   rom_address       fetch address (= fetch_pc)
//   rom_data          ROM read data, valid the cycle after rom_ce
//   halt              level, suppresses new fetches
//   redirect_valid    one-cycle pulse: load redirect_pc and flush
//   redirect_pc       new fetch address
//   instr_valid       buffer head valid
//   instr_ready       decoder accepts the head
//   raw_instruction   buffer head instruction
//   instr_pc          address of raw_instruction
//   pc                current fetch_pc (debug/status)
module instr_fetch #(
  parameter int unsigned              ADDR_WIDTH  = 16,
  parameter int unsigned              INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   rom_ce,
  output logic [ADDR_WIDTH-1:0]  rom_address,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] raw_instruction,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic [ADDR_WIDTH-1:0]  pc
);

  localparam int unsigned OCC_W = 3;

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic                   inflight;
  logic [ADDR_WIDTH-1:0]  inflight_pc;
  logic [1:0]             count;

  // Head entry drives the decoder outputs directly; tail is the second slot.
  logic [INSTR_WIDTH-1:0] head_instr, tail_instr;
  logic [ADDR_WIDTH-1:0]  head_pc, tail_pc;

  logic [1:0]             count_nxt;
  logic [INSTR_WIDTH-1:0] head_instr_nxt, tail_instr_nxt;
  logic [ADDR_WIDTH-1:0]  head_pc_nxt, tail_pc_nxt;

  logic                   pop, push, issue;
  logic [OCC_W-1:0]       occupancy;

  assign instr_valid     = (count != 2'd0);
  assign raw_instruction = head_instr;
  assign instr_pc        = head_pc;
  assign pc              = fetch_pc;
  assign rom_address     = fetch_pc;

  assign pop  = instr_valid & instr_ready;
  // Returning data is dropped in the redirect cycle; it belongs to a squashed path.
  assign push = inflight & ~redirect_valid;

  // Entries buffered plus in flight, less the one leaving this cycle.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);

  // rst_n gating keeps rom_ce low for the whole time reset is held.
  assign issue  = rst_n & ~redirect_valid & ~halt & (occupancy < OCC_W'(2));
  assign rom_ce = issue;

  // Buffer next-state: push/pop bookkeeping, redirect flushes.
  always_comb begin
    count_nxt      = count;
    head_instr_nxt = head_instr;
    head_pc_nxt    = head_pc;
    tail_instr_nxt = tail_instr;
    tail_pc_nxt    = tail_pc;
    if (redirect_valid) begin
      count_nxt = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_instr_nxt = rom_data;
            head_pc_nxt    = inflight_pc;
          end else begin
            tail_instr_nxt = rom_data;
            tail_pc_nxt    = inflight_pc;
          end
          if (count != 2'd2) count_nxt = 2'(count + 2'd1);
        end
        2'b01: begin
          if (count == 2'd2) begin
            head_instr_nxt = tail_instr;
            head_pc_nxt    = tail_pc;
          end
          count_nxt = 2'(count - 2'd1);
        end
        2'b11: begin
          if (count == 2'd2) begin
            head_instr_nxt = tail_instr;
            head_pc_nxt    = tail_pc;
            tail_instr_nxt = rom_data;
            tail_pc_nxt    = inflight_pc;
          end else begin
            head_instr_nxt = rom_data;
            head_pc_nxt    = inflight_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // PC and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
      if (redirect_valid)  fetch_pc <= redirect_pc;
      else if (issue)      fetch_pc <= ADDR_WIDTH'(fetch_pc + 1'b1);
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      head_instr <= '0;
      head_pc    <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else begin
      count      <= count_nxt;
      head_instr <= head_instr_nxt;
      head_pc    <= head_pc_nxt;
      tail_instr <= tail_instr_nxt;
      tail_pc    <= tail_pc_nxt;
    end
  end

  // Issue accounting must never let a landing fetch find the buffer full.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == 2'd2)));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a synchronous ROM model
// whose word at address a is 0x1000 + a.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_ce;
  logic [15:0] rom_address;
  logic [15:0] rom_data = 16'h0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [15:0] raw_instruction;
  logic [15:0] instr_pc;
  logic [15:0] pc;

  int tests_run = 0;
  int fails = 0;
  logic [15:0] exp_pc;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .rom_ce(rom_ce), .rom_address(rom_address),
    .rom_data(rom_data), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .raw_instruction(raw_instruction),
    .instr_pc(instr_pc), .pc(pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_ce) rom_data <= 16'h1000 + rom_address;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return 16'(16'h1000 + a);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Check that the head carries the expected word in consecutive cycles.
  task automatic test_stream(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tests_run++;
      if ({instr_valid, instr_pc, raw_instruction} !== {1'b1, exp_pc, rom_word(exp_pc)}) begin
        fails++;
        $display("FAIL %s[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", name, i,
                 instr_valid, instr_pc, raw_instruction, exp_pc, rom_word(exp_pc));
      end
      exp_pc = 16'(exp_pc + 16'd1);
      tick();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if ({rom_ce, instr_valid, pc, rom_address, raw_instruction, instr_pc} !== {2'b00, 64'h0}) begin
      fails++;
      $display("FAIL reset_values: got ce=%b v=%b pc=%h addr=%h ins=%h ipc=%h want all 0",
               rom_ce, instr_valid, pc, rom_address, raw_instruction, instr_pc);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests_run++;
      if ({rom_ce, rom_address, instr_valid} !== {1'b1, 16'(c), 1'b0}) begin
        fails++;
        $display("FAIL reset_cycle%0d: got ce=%b addr=%h v=%b want ce=1 addr=%h v=0",
                 c, rom_ce, rom_address, instr_valid, 16'(c));
      end
      tick();
    end
    exp_pc = 16'h0000;
    test_stream(5, "reset_stream");
  endtask

  task automatic test_backpressure;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if ({instr_valid, instr_pc, raw_instruction, rom_ce} !== {1'b1, exp_pc, rom_word(exp_pc), 1'b0}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b pc=%h ins=%h ce=%b want v=1 pc=%h ins=%h ce=0",
                 i, instr_valid, instr_pc, raw_instruction, rom_ce, exp_pc, rom_word(exp_pc));
      end
      tick();
    end
    instr_ready = 1'b1;
    test_stream(6, "bp_release");
  endtask

  // Redirect issued with rom_ce suppressed, then two empty cycles, then the new stream.
  task automatic redirect_to(input logic [15:0] target, input logic hold_ready, input string name);
    instr_ready    = hold_ready;
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    tests_run++;
    if (rom_ce !== 1'b0) begin
      fails++;
      $display("FAIL %s_R_ce: got %b want 0", name, rom_ce);
    end
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({instr_valid, rom_ce, rom_address} !== {1'b0, 1'b1, target}) begin
      fails++;
      $display("FAIL %s_R1: got v=%b ce=%b addr=%h want v=0 ce=1 addr=%h",
               name, instr_valid, rom_ce, rom_address, target);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_R2: got v=%b want 0", name, instr_valid);
    end
    tick();
    exp_pc = target;
  endtask

  task automatic test_redirect;
    redirect_to(16'h0040, 1'b0, "redir");
    test_stream(4, "redir_stream");
  endtask

  task automatic test_wrap;
    redirect_to(16'hFFFE, 1'b1, "wrap");
    test_stream(4, "wrap_stream");
  endtask

  task automatic test_halt;
    logic [15:0] resume;
    resume = 16'(exp_pc + 16'd2);
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (i < 2) begin
        if ({rom_ce, pc, instr_valid, instr_pc} !== {1'b0, resume, 1'b1, exp_pc}) begin
          fails++;
          $display("FAIL halt_drain[%0d]: got ce=%b pc=%h v=%b ipc=%h want ce=0 pc=%h v=1 ipc=%h",
                   i, rom_ce, pc, instr_valid, instr_pc, resume, exp_pc);
        end
        exp_pc = 16'(exp_pc + 16'd1);
      end else begin
        if ({rom_ce, pc, instr_valid} !== {1'b0, resume, 1'b0}) begin
          fails++;
          $display("FAIL halt_empty[%0d]: got ce=%b pc=%h v=%b want ce=0 pc=%h v=0",
                   i, rom_ce, pc, instr_valid, resume);
        end
      end
      tick();
    end
    halt = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({rom_ce, rom_address} !== {1'b1, resume}) begin
      fails++;
      $display("FAIL halt_resume: got ce=%b addr=%h want ce=1 addr=%h", rom_ce, rom_address, resume);
    end
    tick();
    tick();
    test_stream(4, "halt_stream");
  endtask

  task automatic test_halt_redirect;
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if ({rom_ce, pc, instr_valid} !== {1'b0, 16'h0100, 1'b0}) begin
        fails++;
        $display("FAIL halt_redir[%0d]: got ce=%b pc=%h v=%b want ce=0 pc=0100 v=0",
                 i, rom_ce, pc, instr_valid);
      end
      tick();
    end
    halt = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({rom_ce, rom_address} !== {1'b1, 16'h0100}) begin
      fails++;
      $display("FAIL halt_redir_resume: got ce=%b addr=%h want ce=1 addr=0100", rom_ce, rom_address);
    end
    tick();
    tick();
    exp_pc = 16'h0100;
    test_stream(3, "halt_redir_stream");
  endtask

  task automatic test_async_reset;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({instr_valid, rom_ce, pc} !== {2'b00, 16'h0000}) begin
      fails++;
      $display("FAIL async_reset: got v=%b ce=%b pc=%h want v=0 ce=0 pc=0000", instr_valid, rom_ce, pc);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    exp_pc = 16'h0000;
    test_stream(4, "async_restart");
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_halt_redirect();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
